// File: rtl/udp_rx_filter.sv
// udp_rx_filter: receive-side Ethernet/IPv4/UDP header parser and address filter.
// Consumes one frame at a time starting at the destination MAC (no preamble/FCS),
// forwards only the UDP payload of frames addressed to this station, and reports
// every frame with a one-cycle frame_ok or frame_drop pulse.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   mac_addr/ip_addr/port   station CSRs, latched at the first byte of each frame
//   rx_valid/rx_data/rx_last  input byte stream (gaps allowed)
//   pl_valid/pl_data/pl_last/pl_err  payload stream, one cycle behind the input
//   pl_len                  UDP length - 8 of the current/last accepted frame
//   frame_ok/frame_drop     per-frame status pulse, one cycle after rx_last
//   drop_cnt                saturating count of dropped frames
module udp_rx_filter #(
    parameter int unsigned OCT = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [6*OCT-1:0]   mac_addr,
    input  logic [4*OCT-1:0]   ip_addr,
    input  logic [2*OCT-1:0]   port,
    input  logic               rx_valid,
    input  logic [OCT-1:0]     rx_data,
    input  logic               rx_last,
    output logic               pl_valid,
    output logic [OCT-1:0]     pl_data,
    output logic               pl_last,
    output logic               pl_err,
    output logic [2*OCT-1:0]   pl_len,
    output logic               frame_ok,
    output logic               frame_drop,
    output logic [2*OCT-1:0]   drop_cnt
);

    typedef enum logic [2:0] {
        StIdle, StEth, StIp, StUdp, StPayload, StPad, StDrop
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [2*OCT-1:0]   cnt_q, cnt_d;
    logic [6*OCT-1:0]   mac_q, mac_d;
    logic [4*OCT-1:0]   ip_q, ip_d;
    logic [2*OCT-1:0]   port_q, port_d;
    logic               ucast_q, ucast_d, bcast_q, bcast_d;
    logic [OCT-1:0]     len_hi_q, len_hi_d;
    logic [2*OCT-1:0]   udp_len_q, udp_len_d;
    logic               pl_valid_d, pl_last_d, pl_err_d, frame_ok_d, frame_drop_d;
    logic [OCT-1:0]     pl_data_d;
    logic [2*OCT-1:0]   pl_len_d;

    // Byte 0 arrives in IDLE and must be compared against the live CSRs,
    // which are latched at that same edge.
    logic [6*OCT-1:0]   cur_mac;
    logic [4*OCT-1:0]   cur_ip;
    logic [2*OCT-1:0]   cur_port;
    logic [5:0]         byte_idx;
    logic [OCT-1:0]     mac_byte, exp_byte;
    logic               chk, ucast_n, bcast_n, hdr_ok;
    logic [2*OCT-1:0]   udp_len_n;

    assign cur_mac  = (state_q == StIdle) ? mac_addr : mac_q;
    assign cur_ip   = (state_q == StIdle) ? ip_addr  : ip_q;
    assign cur_port = (state_q == StIdle) ? port     : port_q;
    assign byte_idx = (state_q == StIdle) ? 6'd0     : idx_q;

    always_comb begin
        mac_byte = '0;
        exp_byte = '0;
        chk      = 1'b0;
        case (byte_idx)
            6'd0:  mac_byte = cur_mac[6*OCT-1 -: OCT];
            6'd1:  mac_byte = cur_mac[5*OCT-1 -: OCT];
            6'd2:  mac_byte = cur_mac[4*OCT-1 -: OCT];
            6'd3:  mac_byte = cur_mac[3*OCT-1 -: OCT];
            6'd4:  mac_byte = cur_mac[2*OCT-1 -: OCT];
            6'd5:  mac_byte = cur_mac[OCT-1:0];
            6'd12: begin chk = 1'b1; exp_byte = OCT'(8'h08); end
            6'd13: begin chk = 1'b1; exp_byte = OCT'(8'h00); end
            6'd14: begin chk = 1'b1; exp_byte = OCT'(8'h45); end
            6'd23: begin chk = 1'b1; exp_byte = OCT'(8'h11); end
            6'd30: begin chk = 1'b1; exp_byte = cur_ip[4*OCT-1 -: OCT]; end
            6'd31: begin chk = 1'b1; exp_byte = cur_ip[3*OCT-1 -: OCT]; end
            6'd32: begin chk = 1'b1; exp_byte = cur_ip[2*OCT-1 -: OCT]; end
            6'd33: begin chk = 1'b1; exp_byte = cur_ip[OCT-1:0]; end
            6'd36: begin chk = 1'b1; exp_byte = cur_port[2*OCT-1 -: OCT]; end
            6'd37: begin chk = 1'b1; exp_byte = cur_port[OCT-1:0]; end
            default: ;
        endcase
    end

    // Unicast and broadcast are tracked separately; the frame survives the MAC
    // field while either is still possible.
    always_comb begin
        ucast_n = (state_q == StIdle) ? 1'b1 : ucast_q;
        bcast_n = (state_q == StIdle) ? 1'b1 : bcast_q;
        if (byte_idx < 6'd6) begin
            ucast_n = ucast_n & (rx_data == mac_byte);
            bcast_n = bcast_n & (rx_data == '1);
        end
        udp_len_n = {len_hi_q, rx_data};
        hdr_ok    = (ucast_n | bcast_n) & (~chk | (rx_data == exp_byte));
        if ((byte_idx == 6'd39) && (udp_len_n < (2*OCT)'(8))) begin
            hdr_ok = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mac_d        = mac_q;
        ip_d         = ip_q;
        port_d       = port_q;
        ucast_d      = ucast_q;
        bcast_d      = bcast_q;
        len_hi_d     = len_hi_q;
        udp_len_d    = udp_len_q;
        pl_valid_d   = 1'b0;
        pl_data_d    = pl_data;
        pl_last_d    = 1'b0;
        pl_err_d     = 1'b0;
        pl_len_d     = pl_len;
        frame_ok_d   = 1'b0;
        frame_drop_d = 1'b0;
        if (rx_valid) begin
            case (state_q)
                StIdle, StEth, StIp, StUdp: begin
                    if (state_q == StIdle) begin
                        mac_d  = mac_addr;
                        ip_d   = ip_addr;
                        port_d = port;
                    end
                    ucast_d = ucast_n;
                    bcast_d = bcast_n;
                    if (byte_idx == 6'd38) len_hi_d = rx_data;
                    if (byte_idx == 6'd39) udp_len_d = udp_len_n;
                    idx_d = byte_idx + 6'd1;
                    if (rx_last) begin
                        frame_drop_d = 1'b1;
                        state_d      = StIdle;
                    end else if (!hdr_ok) begin
                        state_d = StDrop;
                    end else if (byte_idx == 6'd13) begin
                        state_d = StIp;
                    end else if (byte_idx == 6'd33) begin
                        state_d = StUdp;
                    end else if (byte_idx == 6'd41) begin
                        pl_len_d = udp_len_q - (2*OCT)'(8);
                        cnt_d    = '0;
                        state_d  = (udp_len_q == (2*OCT)'(8)) ? StPad : StPayload;
                    end else if (state_q == StIdle) begin
                        state_d = StEth;
                    end
                end
                StPayload: begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = rx_data;
                    cnt_d      = cnt_q + (2*OCT)'(1);
                    if (cnt_d == pl_len) begin
                        pl_last_d  = 1'b1;
                        frame_ok_d = rx_last;
                        state_d    = rx_last ? StIdle : StPad;
                    end else if (rx_last) begin
                        pl_last_d    = 1'b1;
                        pl_err_d     = 1'b1;
                        frame_drop_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
                StPad: begin
                    if (rx_last) begin
                        frame_ok_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
                StDrop: begin
                    if (rx_last) begin
                        frame_drop_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            mac_q      <= '0;
            ip_q       <= '0;
            port_q     <= '0;
            ucast_q    <= 1'b0;
            bcast_q    <= 1'b0;
            len_hi_q   <= '0;
            udp_len_q  <= '0;
            pl_valid   <= 1'b0;
            pl_data    <= '0;
            pl_last    <= 1'b0;
            pl_err     <= 1'b0;
            pl_len     <= '0;
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mac_q      <= mac_d;
            ip_q       <= ip_d;
            port_q     <= port_d;
            ucast_q    <= ucast_d;
            bcast_q    <= bcast_d;
            len_hi_q   <= len_hi_d;
            udp_len_q  <= udp_len_d;
            pl_valid   <= pl_valid_d;
            pl_data    <= pl_data_d;
            pl_last    <= pl_last_d;
            pl_err     <= pl_err_d;
            pl_len     <= pl_len_d;
            frame_ok   <= frame_ok_d;
            frame_drop <= frame_drop_d;
            if (frame_drop_d && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + (2*OCT)'(1);
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_filter.sv
// Scoreboard bench for udp_rx_filter: stimulus pushes expected payload beats and
// status pulses (with their due cycle) into queues; a negedge monitor pops and
// compares whenever the DUT presents a beat or a status pulse.
module tb_udp_rx_filter;

    localparam int KAccept = 0;
    localparam int KDrop   = 1;
    localparam int KTrunc  = 2;

    localparam logic [47:0] MyMac = 48'h02_00_00_00_00_01;
    localparam logic [31:0] MyIp  = 32'h0A_00_00_02;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [47:0] mac_addr;
    logic [31:0] ip_addr;
    logic [15:0] port;
    logic        rx_valid, rx_last;
    logic [7:0]  rx_data;
    logic        pl_valid, pl_last, pl_err, frame_ok, frame_drop;
    logic [7:0]  pl_data;
    logic [15:0] pl_len, drop_cnt;

    udp_rx_filter dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .mac_addr   (mac_addr),
        .ip_addr    (ip_addr),
        .port       (port),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_last    (rx_last),
        .pl_valid   (pl_valid),
        .pl_data    (pl_data),
        .pl_last    (pl_last),
        .pl_err     (pl_err),
        .pl_len     (pl_len),
        .frame_ok   (frame_ok),
        .frame_drop (frame_drop),
        .drop_cnt   (drop_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic        e;
        logic [15:0] len;
        logic [31:0] cyc;
    } beat_t;

    typedef struct packed {
        logic        ok;
        logic        drop;
        logic [31:0] cyc;
    } stat_t;

    beat_t       beat_q[$];
    stat_t       stat_q[$];
    logic [7:0]  frm[$];
    logic [7:0]  pay[$];
    logic [31:0] cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          csr_at = -1;
    logic [15:0] csr_port;
    int          stop_at = -1;
    beat_t       eb;
    stat_t       es;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (pl_valid) begin
                check("beat_expected", 64'(beat_q.size() != 0), 64'd1);
                if (beat_q.size() != 0) begin
                    eb = beat_q.pop_front();
                    check("beat", {6'd0, pl_data, pl_last, pl_err, pl_len, cyc}, 64'(eb));
                end
            end
            if (frame_ok || frame_drop) begin
                check("status_expected", 64'(stat_q.size() != 0), 64'd1);
                if (stat_q.size() != 0) begin
                    es = stat_q.pop_front();
                    check("status", 64'({frame_ok, frame_drop, cyc}), 64'(es));
                end
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic last);
        @(posedge wb_clk_i);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        rx_last  = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
            rx_valid = 1'b0;
            rx_last  = 1'b0;
        end
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [7:0] b14, input logic [7:0] proto,
                         input logic [31:0] dip, input logic [15:0] dport,
                         input logic [15:0] ulen, input int npad);
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
        frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h99);
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        frm.push_back(b14); frm.push_back(8'h00);
        for (int i = 16; i < 22; i++) frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(proto);
        frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h0A); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
        for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
        frm.push_back(8'h04); frm.push_back(8'h00);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        foreach (pay[i]) frm.push_back(pay[i]);
        for (int i = 0; i < npad; i++) frm.push_back(8'h00);
    endtask

    // npay: beats expected to be forwarded; elen: expected pl_len on those beats.
    task automatic send_frame(input int kind, input int npay, input logic [15:0] elen,
                              input bit gaps);
        int    n;
        beat_t b;
        stat_t s;
        n = (stop_at > 0) ? stop_at : frm.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 2));
            drive(frm[i], i == frm.size() - 1);
            if (i == csr_at) port = csr_port;
            if (kind != KDrop && i >= 42 && i < 42 + npay) begin
                b.d   = frm[i];
                b.l   = (i == 42 + npay - 1);
                b.e   = (kind == KTrunc) && (i == 42 + npay - 1);
                b.len = elen;
                b.cyc = cyc + 1;
                beat_q.push_back(b);
            end
            if (i == frm.size() - 1) begin
                s.ok   = (kind == KAccept);
                s.drop = (kind != KAccept);
                s.cyc  = cyc + 1;
                stat_q.push_back(s);
            end
        end
    endtask

    task automatic set_pay4(input logic [31:0] w);
        pay.delete();
        for (int i = 3; i >= 0; i--) pay.push_back(w[i*8 +: 8]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stat_t s;
        mac_addr = MyMac;
        ip_addr  = MyIp;
        port     = 16'h1234;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("rst_pl_valid", 64'(pl_valid), 64'd0);
        check("rst_status", 64'({frame_ok, frame_drop}), 64'd0);
        check("rst_pl_data", 64'(pl_data), 64'd0);
        check("rst_pl_len", 64'(pl_len), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Unicast match
        set_pay4(32'hDEADBEEF);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KAccept, 4, 16'd4, 1'b0);
        idle(4);
        check("unicast_drop_cnt", 64'(drop_cnt), 64'd0);

        // Broadcast and filtering
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KAccept, 4, 16'd4, 1'b0);
        build(48'h02_00_00_00_00_02, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KDrop, 0, 16'd0, 1'b0);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1235, 16'd12, 18);
        send_frame(KDrop, 0, 16'd0, 1'b0);
        idle(4);
        check("filter_drop_cnt", 64'(drop_cnt), 64'd2);

        // Header rejects
        build(MyMac, 16'h86DD, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KDrop, 0, 16'd0, 1'b0);
        build(MyMac, 16'h0800, 8'h46, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KDrop, 0, 16'd0, 1'b0);
        build(MyMac, 16'h0800, 8'h45, 8'h06, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KDrop, 0, 16'd0, 1'b0);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd7, 18);
        send_frame(KDrop, 0, 16'd0, 1'b0);
        idle(4);
        check("hdr_drop_cnt", 64'(drop_cnt), 64'd6);

        // Truncation inside the payload: 50 of 100 bytes
        pay.delete();
        for (int i = 0; i < 100; i++) pay.push_back(8'(i + 1));
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd108, 0);
        while (frm.size() > 92) void'(frm.pop_back());
        send_frame(KTrunc, 50, 16'd100, 1'b0);
        // Truncation inside the IP header (rx_last at byte 20)
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        while (frm.size() > 21) void'(frm.pop_back());
        send_frame(KDrop, 0, 16'd0, 1'b0);
        idle(4);
        check("trunc_drop_cnt", 64'(drop_cnt), 64'd8);

        // CSR change mid-frame plus back-to-back frames with input gaps
        set_pay4(32'h11223344);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        csr_at   = 10;
        csr_port = 16'h5678;
        send_frame(KAccept, 4, 16'd4, 1'b1);
        csr_at = -1;
        set_pay4(32'hA5C3_0F01);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h5678, 16'd12, 18);
        send_frame(KAccept, 4, 16'd4, 1'b1);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KDrop, 0, 16'd0, 1'b1);
        idle(4);
        check("csr_drop_cnt", 64'(drop_cnt), 64'd9);
        port = 16'h1234;

        // Asynchronous reset in the middle of the payload
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'(8'h80 + i));
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd28, 0);
        stop_at = 45;
        send_frame(KAccept, 20, 16'd20, 1'b0);
        stop_at = -1;
        @(posedge wb_clk_i);
        #3;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        check("arst_pl_valid", 64'(pl_valid), 64'd0);
        check("arst_pl_data", 64'(pl_data), 64'd0);
        check("arst_pl_flags", 64'({pl_last, pl_err}), 64'd0);
        check("arst_pl_len", 64'(pl_len), 64'd0);
        check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        beat_q.delete();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        set_pay4(32'hCAFEF00D);
        build(MyMac, 16'h0800, 8'h45, 8'h11, MyIp, 16'h1234, 16'd12, 18);
        send_frame(KAccept, 4, 16'd4, 1'b0);
        idle(4);
        check("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Saturation: one-byte frames are drops, back-to-back every cycle
        for (int i = 0; i < 65534; i++) begin
            drive(8'h00, 1'b1);
            s.ok   = 1'b0;
            s.drop = 1'b1;
            s.cyc  = cyc + 1;
            stat_q.push_back(s);
        end
        idle(3);
        check("sat_fffe", 64'(drop_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(8'h00, 1'b1);
            s.ok   = 1'b0;
            s.drop = 1'b1;
            s.cyc  = cyc + 1;
            stat_q.push_back(s);
        end
        idle(3);
        check("sat_ffff", 64'(drop_cnt), 64'hFFFF);

        idle(5);
        check("beats_drained", 64'(beat_q.size()), 64'd0);
        check("status_drained", 64'(stat_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
